// File: rtl/cdc_fifo_gray_pkg.sv
// Shared definitions for the gray-pointer FIFO read-side controller.
//   rd_flush_state_e : flush engine states (IDLE, FLUSH, DONE)
//   ptr_width()      : pointer width for a given log2 depth (one extra wrap bit)
package cdc_fifo_gray_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } rd_flush_state_e;

   function automatic int ptr_width(input int log_depth);
      return log_depth + 1;
   endfunction

endpackage

// File: rtl/cdc_fifo_gray_rd_ctrl_if.sv
// Consumer-side output stream of the FIFO read controller.
//   data  : payload, driven by the master
//   valid : master has a word on data
//   ready : slave accepts the word
// Handshake: a word moves on a rising clock edge where valid and ready are both
// high. While valid is high and ready is low, the master holds data and valid
// unchanged. ready may be asserted at any time and never depends on valid.
interface cdc_fifo_gray_rd_ctrl_if #(
   parameter type T = logic
) ();
   T     data;
   logic valid;
   logic ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cdc_fifo_gray_cells.sv
// Generic CDC helper cells.
//   sync           : STAGES-flop synchronizer (clk_i, rst_ni, serial_i -> serial_o)
//   gray_to_binary : combinational gray -> binary, N bits (A_i -> Z_o)
//   binary_to_gray : combinational binary -> gray, N bits (A_i -> Z_o)
module sync #(
   parameter int unsigned STAGES      = 2,
   parameter logic        RESET_VALUE = 1'b0
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic serial_i,
   output logic serial_o
);
   logic [STAGES-1:0] reg_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) reg_q <= {STAGES{RESET_VALUE}};
      else         reg_q <= {reg_q[STAGES-2:0], serial_i};
   end

   assign serial_o = reg_q[STAGES-1];
endmodule

module gray_to_binary #(
   parameter int N = 4
) (
   input  logic [N-1:0] A_i,
   output logic [N-1:0] Z_o
);
   // Each binary bit is the XOR of all gray bits at or above it.
   for (genvar i = 0; i < N; i++) begin : g_bit
      assign Z_o[i] = ^A_i[N-1:i];
   end
endmodule

module binary_to_gray #(
   parameter int N = 4
) (
   input  logic [N-1:0] A_i,
   output logic [N-1:0] Z_o
);
   assign Z_o = A_i ^ (A_i >> 1);
endmodule

// File: rtl/cdc_fifo_gray_rd_outbuf.sv
// Two-entry registered output buffer, FIFO order.
//   clr_i       : synchronous clear (dominates push/pop)
//   push_i      : write push_data_i behind the current contents
//   pop_i       : drop the head entry
//   head_o      : oldest entry (stale but stable when empty)
//   count_o     : number of valid entries, 0..2
module cdc_fifo_gray_rd_outbuf #(
   parameter type T = logic
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       push_i,
   input  T           push_data_i,
   input  logic       pop_i,
   output T           head_o,
   output logic [1:0] count_o
);
   T           ent0_q, ent0_d, ent1_q, ent1_d;
   logic [1:0] cnt_q, cnt_d;

   always_comb begin
      ent0_d = ent0_q;
      ent1_d = ent1_q;
      cnt_d  = cnt_q;
      if (clr_i) begin
         cnt_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b11: begin
               // Count is unchanged; the new word lands behind whatever remains.
               if (cnt_q == 2'd2) begin
                  ent0_d = ent1_q;
                  ent1_d = push_data_i;
               end else begin
                  ent0_d = push_data_i;
               end
            end
            2'b01: begin
               ent0_d = ent1_q;
               cnt_d  = cnt_q - 2'd1;
            end
            2'b10: begin
               if (cnt_q == 2'd0) ent0_d = push_data_i;
               else               ent1_d = push_data_i;
               cnt_d = cnt_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
         cnt_q  <= cnt_d;
      end
   end

   assign head_o  = ent0_q;
   assign count_o = cnt_q;
endmodule

// File: rtl/cdc_fifo_gray_rd_ctrl.sv
// Read-side controller of a gray-pointer asynchronous FIFO, consumer domain.
//   clk_i, rst_ni    : consumer clock, asynchronous active-low reset
//   async_data_i     : FIFO storage exposed by the write side
//   async_wptr_i     : gray write pointer from the write side
//   async_rptr_o     : registered gray read pointer back to the write side
//   dst              : output stream (data/valid/ready), two-entry buffered
//   flush_i          : one-cycle request to discard everything written so far
//   flush_busy_o     : flush engine is discarding words
//   flush_done_o     : one-cycle pulse when the flush completes
//   fill_o           : words in the FIFO not yet pulled into the output buffer
//   almost_empty_o   : fill_o <= AE_THRESH
//   state_o          : flush engine state
module cdc_fifo_gray_rd_ctrl
   import cdc_fifo_gray_pkg::*;
#(
   parameter type         T           = logic,
   parameter int unsigned LOG_DEPTH   = 3,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned AE_THRESH   = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  T                        async_data_i [2**LOG_DEPTH],
   input  logic [LOG_DEPTH:0]      async_wptr_i,
   output logic [LOG_DEPTH:0]      async_rptr_o,
   cdc_fifo_gray_rd_ctrl_if.master dst,
   input  logic                    flush_i,
   output logic                    flush_busy_o,
   output logic                    flush_done_o,
   output logic [LOG_DEPTH:0]      fill_o,
   output logic                    almost_empty_o,
   output rd_flush_state_e         state_o
);
   localparam int PW = ptr_width(int'(LOG_DEPTH));
   localparam logic [PW-1:0] AE_LIM   = PW'(AE_THRESH);
   localparam logic [PW-1:0] FULL_LVL = PW'(2**LOG_DEPTH);

   logic [PW-1:0]   wptr_gray_sync, wptr_bin, fill;
   logic [PW-1:0]   rptr_bin_q, rptr_bin_d, rptr_gray_q, rptr_gray_d;
   logic [PW-1:0]   flush_tgt_q, flush_tgt_d;
   rd_flush_state_e state_q, state_d;
   logic            pop, buf_clr, buf_push, buf_pop;
   logic [1:0]      buf_count;
   T                buf_head;

   // Every pointer bit gets its own synchronizer; the write side changes only
   // one gray bit at a time, so the sampled word is always a real pointer value.
   for (genvar i = 0; i < PW; i++) begin : g_wsync
      sync #(.STAGES(SYNC_STAGES)) u_sync (
         .clk_i    (clk_i),
         .rst_ni   (rst_ni),
         .serial_i (async_wptr_i[i]),
         .serial_o (wptr_gray_sync[i])
      );
   end

   gray_to_binary #(.N(PW)) u_w_g2b (.A_i(wptr_gray_sync), .Z_o(wptr_bin));

   assign fill = wptr_bin - rptr_bin_q;

   // Flush engine and pop decision. Pop never looks at dst.ready, so the
   // pointer returned to the write side has no combinational ready path.
   always_comb begin
      state_d      = state_q;
      flush_tgt_d  = flush_tgt_q;
      pop          = 1'b0;
      buf_clr      = 1'b0;
      flush_busy_o = 1'b0;
      flush_done_o = 1'b0;
      case (state_q)
         IDLE: begin
            pop = (fill != '0) && (buf_count < 2'd2);
            if (flush_i) begin
               // Anything popped this cycle is older than the snapshot, so the
               // clear discarding it is exactly what the flush wants.
               flush_tgt_d = wptr_bin;
               buf_clr     = 1'b1;
               state_d     = FLUSH;
            end
         end
         FLUSH: begin
            flush_busy_o = 1'b1;
            if (rptr_bin_q == flush_tgt_q) state_d = DONE;
            else                           pop     = (fill != '0);
         end
         DONE: begin
            flush_done_o = 1'b1;
            pop          = (fill != '0) && (buf_count < 2'd2);
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign buf_push   = pop && (state_q != FLUSH);
   assign rptr_bin_d = rptr_bin_q + {{(PW-1){1'b0}}, pop};

   binary_to_gray #(.N(PW)) u_r_b2g (.A_i(rptr_bin_d), .Z_o(rptr_gray_d));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rptr_bin_q  <= '0;
         rptr_gray_q <= '0;
         flush_tgt_q <= '0;
         state_q     <= IDLE;
      end else begin
         rptr_bin_q  <= rptr_bin_d;
         rptr_gray_q <= rptr_gray_d;
         flush_tgt_q <= flush_tgt_d;
         state_q     <= state_d;
      end
   end

   cdc_fifo_gray_rd_outbuf #(.T(T)) u_outbuf (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .clr_i       (buf_clr),
      .push_i      (buf_push),
      .push_data_i (async_data_i[rptr_bin_q[LOG_DEPTH-1:0]]),
      .pop_i       (buf_pop),
      .head_o      (buf_head),
      .count_o     (buf_count)
   );

   assign dst.valid      = (buf_count != 2'd0) && (state_q == IDLE);
   assign dst.data       = buf_head;
   assign buf_pop        = dst.valid && dst.ready;
   assign async_rptr_o   = rptr_gray_q;
   assign fill_o         = fill;
   assign almost_empty_o = (fill <= AE_LIM);
   assign state_o        = state_q;

   a_fill_range: assert property (@(posedge clk_i) disable iff (!rst_ni) fill <= FULL_LVL);
endmodule

// File: tb/tb_cdc_fifo_gray_rd_ctrl.sv
module tb_cdc_fifo_gray_rd_ctrl;
   import cdc_fifo_gray_pkg::*;

   typedef logic [7:0] word_t;

   // ---------------- clock / reset ----------------
   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   word_t           mem [8];
   logic [3:0]      async_wptr = 4'd0;
   logic [3:0]      async_rptr, fill;
   logic            flush_i = 1'b0;
   logic            busy, done, ae;
   rd_flush_state_e state;

   cdc_fifo_gray_rd_ctrl_if #(.T(word_t)) dst_if ();

   cdc_fifo_gray_rd_ctrl #(
      .T(word_t), .LOG_DEPTH(3), .SYNC_STAGES(2), .AE_THRESH(1)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .async_data_i   (mem),
      .async_wptr_i   (async_wptr),
      .async_rptr_o   (async_rptr),
      .dst            (dst_if),
      .flush_i        (flush_i),
      .flush_busy_o   (busy),
      .flush_done_o   (done),
      .fill_o         (fill),
      .almost_empty_o (ae),
      .state_o        (state)
   );

   // ---------------- scoreboard state ----------------
   int         total = 0;
   int         bad   = 0;
   word_t      exp_q [$];
   logic [3:0] wbin = 4'd0;
   int         wr_left = 0;
   bit         wr_keep = 1'b1;
   word_t      wr_data = 8'h10;
   int         busy_cnt = 0;
   int         done_cnt = 0;
   logic [3:0] prev_rptr = 4'd0;
   bit         saw_wrap = 1'b0;

   function automatic logic [3:0] bin2gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] gray2bin(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      if (dst_if.valid && dst_if.ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL beat: got 0x%0h expected none", dst_if.data);
         end else begin
            check("beat", 32'(dst_if.data), 32'(exp_q.pop_front()));
         end
      end
      check("fill range", 32'(fill <= 4'd8), 32'd1);
      check("ae vs fill", 32'(ae), 32'(fill <= 4'd1));
      if (busy) begin
         busy_cnt++;
         check("valid in flush", 32'(dst_if.valid), 32'd0);
      end
      if (done) begin
         done_cnt++;
         check("busy at done", 32'(busy), 32'd0);
      end
      if (prev_rptr == 4'b1000 && async_rptr == 4'b0000) saw_wrap = 1'b1;
      prev_rptr = async_rptr;
   endtask

   // ---------------- driver ----------------
   // One cycle: the write-side model may publish one word just after the edge,
   // then ready/flush are set at the falling edge and the outputs are checked.
   task automatic tick(input bit rdy, input bit fl);
      @(posedge clk_i);
      #1;
      if (wr_left > 0 && 4'(wbin - gray2bin(async_rptr)) < 4'd8) begin
         mem[wbin[2:0]] = wr_data;
         if (wr_keep) exp_q.push_back(wr_data);
         wr_data    = wr_data + 8'd1;
         wbin       = wbin + 4'd1;
         async_wptr = bin2gray(wbin);
         wr_left--;
      end
      @(negedge clk_i);
      dst_if.ready = rdy;
      flush_i      = fl;
      monitor();
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic [3:0] wptr;
      logic       ready;
      logic [3:0] fill;
      logic       valid;
      word_t      data;
      logic [3:0] rptr;
      logic       ae;
   } vec_t;

   vec_t tbl [23];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int b0, d0;
      word_t first;

      // Streaming: pointer steps 0->1->3->2 (3 words), then 6 (4th word).
      tbl[0]  = '{4'd1,  1'b1, 4'd0, 1'b0, 8'h00, 4'd0,  1'b1};
      tbl[1]  = '{4'd3,  1'b1, 4'd0, 1'b0, 8'h00, 4'd0,  1'b1};
      tbl[2]  = '{4'd2,  1'b1, 4'd1, 1'b0, 8'h00, 4'd0,  1'b1};
      tbl[3]  = '{4'd2,  1'b1, 4'd1, 1'b1, 8'hA0, 4'd1,  1'b1};
      tbl[4]  = '{4'd2,  1'b1, 4'd1, 1'b1, 8'hA1, 4'd3,  1'b1};
      tbl[5]  = '{4'd2,  1'b1, 4'd0, 1'b1, 8'hA2, 4'd2,  1'b1};
      tbl[6]  = '{4'd6,  1'b1, 4'd0, 1'b0, 8'h00, 4'd2,  1'b1};
      tbl[7]  = '{4'd6,  1'b1, 4'd0, 1'b0, 8'h00, 4'd2,  1'b1};
      tbl[8]  = '{4'd6,  1'b1, 4'd1, 1'b0, 8'h00, 4'd2,  1'b1};
      tbl[9]  = '{4'd6,  1'b1, 4'd0, 1'b1, 8'hA3, 4'd6,  1'b1};
      tbl[10] = '{4'd6,  1'b1, 4'd0, 1'b0, 8'h00, 4'd6,  1'b1};
      // Backpressure: 4 more words with ready low, then release.
      tbl[11] = '{4'd7,  1'b0, 4'd0, 1'b0, 8'h00, 4'd6,  1'b1};
      tbl[12] = '{4'd5,  1'b0, 4'd0, 1'b0, 8'h00, 4'd6,  1'b1};
      tbl[13] = '{4'd4,  1'b0, 4'd1, 1'b0, 8'h00, 4'd6,  1'b1};
      tbl[14] = '{4'd12, 1'b0, 4'd1, 1'b1, 8'hB0, 4'd7,  1'b1};
      tbl[15] = '{4'd12, 1'b0, 4'd1, 1'b1, 8'hB0, 4'd5,  1'b1};
      tbl[16] = '{4'd12, 1'b0, 4'd2, 1'b1, 8'hB0, 4'd5,  1'b0};
      tbl[17] = '{4'd12, 1'b0, 4'd2, 1'b1, 8'hB0, 4'd5,  1'b0};
      tbl[18] = '{4'd12, 1'b1, 4'd2, 1'b1, 8'hB0, 4'd5,  1'b0};
      tbl[19] = '{4'd12, 1'b1, 4'd2, 1'b1, 8'hB1, 4'd5,  1'b0};
      tbl[20] = '{4'd12, 1'b1, 4'd1, 1'b1, 8'hB2, 4'd4,  1'b1};
      tbl[21] = '{4'd12, 1'b1, 4'd0, 1'b1, 8'hB3, 4'd12, 1'b1};
      tbl[22] = '{4'd12, 1'b1, 4'd0, 1'b0, 8'h00, 4'd12, 1'b1};

      mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
      mem[4] = 8'hB0; mem[5] = 8'hB1; mem[6] = 8'hB2; mem[7] = 8'hB3;
      dst_if.ready = 1'b1;

      // Reset values, no clock edge yet.
      #2;
      check("rst rptr",  32'(async_rptr),    32'd0);
      check("rst fill",  32'(fill),          32'd0);
      check("rst ae",    32'(ae),            32'd1);
      check("rst valid", 32'(dst_if.valid),  32'd0);
      check("rst data",  32'(dst_if.data),   32'd0);
      check("rst busy",  32'(busy),          32'd0);
      check("rst done",  32'(done),          32'd0);
      check("rst state", 32'(state),         32'(IDLE));

      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // Table: apply inputs after an edge, check at the falling edge.
      for (int i = 0; i < 23; i++) begin
         async_wptr   = tbl[i].wptr;
         dst_if.ready = tbl[i].ready;
         @(negedge clk_i);
         check($sformatf("tbl[%0d] fill", i),  32'(fill),         32'(tbl[i].fill));
         check($sformatf("tbl[%0d] valid", i), 32'(dst_if.valid), 32'(tbl[i].valid));
         if (tbl[i].valid)
            check($sformatf("tbl[%0d] data", i), 32'(dst_if.data), 32'(tbl[i].data));
         check($sformatf("tbl[%0d] rptr", i),  32'(async_rptr),   32'(tbl[i].rptr));
         check($sformatf("tbl[%0d] ae", i),    32'(ae),           32'(tbl[i].ae));
         @(posedge clk_i);
         #1;
      end

      // Wrap: 20 words with random ready; read pointer passes bin 15 -> 0.
      wbin      = 4'd8;
      prev_rptr = async_rptr;
      saw_wrap  = 1'b0;
      wr_left   = 20;
      wr_keep   = 1'b1;
      for (int c = 0; c < 600 && (wr_left > 0 || exp_q.size() > 0); c++)
         tick(1'($urandom_range(0, 1)), 1'b0);
      check("wrap drained", 32'(exp_q.size() + wr_left), 32'd0);
      check("rptr wrap", 32'(saw_wrap), 32'd1);

      // Flush: 7 words pending (2 buffered, 5 in FIFO), 2 more written during flush.
      first   = wr_data;
      wr_left = 7;
      wr_keep = 1'b0;
      repeat (11) tick(1'b0, 1'b0);
      check("pre-flush fill", 32'(fill), 32'd5);
      check("pre-flush head", 32'(dst_if.data), 32'(first));
      b0 = busy_cnt;
      d0 = done_cnt;
      tick(1'b0, 1'b1);
      wr_left = 2;
      wr_keep = 1'b1;
      tick(1'b1, 1'b0);
      check("flush entered", 32'(busy), 32'd1);
      for (int c = 0; c < 60 && (exp_q.size() > 0 || wr_left > 0 || done_cnt == d0); c++)
         tick(1'b1, 1'b0);
      // 5 pop cycles plus the cycle that sees the pointer reach the target.
      check("flush busy cycles", 32'(busy_cnt - b0), 32'd6);
      check("flush done pulses", 32'(done_cnt - d0), 32'd1);
      check("post-flush drained", 32'(exp_q.size()), 32'd0);

      // Reset in the middle of a flush.
      wr_left = 4;
      wr_keep = 1'b0;
      repeat (8) tick(1'b0, 1'b0);
      d0 = done_cnt;
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      check("flush before reset", 32'(busy), 32'd1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("mid rst rptr",  32'(async_rptr),   32'd0);
      check("mid rst fill",  32'(fill),         32'd0);
      check("mid rst ae",    32'(ae),           32'd1);
      check("mid rst valid", 32'(dst_if.valid), 32'd0);
      check("mid rst busy",  32'(busy),         32'd0);
      check("mid rst state", 32'(state),        32'(IDLE));
      wbin       = 4'd0;
      async_wptr = 4'd0;
      wr_left    = 0;
      exp_q.delete();
      prev_rptr  = 4'd0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
      repeat (6) tick(1'b1, 1'b0);
      check("no done after reset", 32'(done_cnt - d0), 32'd0);
      check("idle after reset", 32'(state), 32'(IDLE));
      wr_left = 4;
      wr_keep = 1'b1;
      for (int c = 0; c < 60 && (wr_left > 0 || exp_q.size() > 0); c++)
         tick(1'b1, 1'b0);
      check("resume drained", 32'(exp_q.size() + wr_left), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
